// File: rtl/pcie_os_pkg.sv
// rtl/pcie_os_pkg.sv - shared constants, os type codes and lane slot helper for the OS analyzer
package pcie_os_pkg;

  localparam int MAXLANES = 16;
  localparam int LANEW    = 128;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  typedef enum logic [1:0] {
    OS_NONE  = 2'b00,
    OS_TS1   = 2'b01,
    OS_TS2   = 2'b10,
    OS_OTHER = 2'b11
  } os_type_e;

  // Bit offset of symbol sym of lane slot lane inside the ordered-set word
  function automatic int unsigned lane_offset(input int unsigned lane, input int unsigned sym);
    return lane * LANEW + sym * 8;
  endfunction

endpackage

// File: rtl/lane_ts_classifier.sv
// rtl/lane_ts_classifier.sv - per-lane TS1/TS2 recognition and symbol 1..5 extraction
module lane_ts_classifier
  import pcie_os_pkg::*;
(
  input  logic [LANEW-1:0] slot,
  output logic             is_ts1,
  output logic             is_ts2,
  output logic [7:0]       sym1,
  output logic [7:0]       sym2,
  output logic [7:0]       sym3,
  output logic [7:0]       sym4,
  output logic [7:0]       sym5
);

  // COM in symbol 0 plus a uniform TS identifier in symbols 6..15
  always_comb begin
    is_ts1 = (slot[7:0] == COM);
    is_ts2 = (slot[7:0] == COM);
    for (int s = 6; s < 16; s++) begin
      if (slot[s*8 +: 8] != TS1_ID) is_ts1 = 1'b0;
      if (slot[s*8 +: 8] != TS2_ID) is_ts2 = 1'b0;
    end
  end

  assign sym1 = slot[15:8];
  assign sym2 = slot[23:16];
  assign sym3 = slot[31:24];
  assign sym4 = slot[39:32];
  assign sym5 = slot[47:40];

endmodule

// File: rtl/os_analyzer.sv
// rtl/os_analyzer.sv - training-sequence classifier with consecutive TS1/TS2 qualification
module os_analyzer
  import pcie_os_pkg::*;
#(
  parameter int COUNTW = 4,
  parameter int TARGET = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      osValid,
  input  logic [MAXLANES*LANEW-1:0] orderedSets,
  input  logic [4:0]                numberOfDetectedLanes,
  input  logic                      clearCounters,
  output logic                      tsValid,
  output logic [1:0]                osType,
  output logic [7:0]                linkNumber,
  output logic [MAXLANES*8-1:0]     laneNumbers,
  output logic [7:0]                nFts,
  output logic [7:0]                rateId,
  output logic [7:0]                trainCtrl,
  output logic                      linkPad,
  output logic                      lanePad,
  output logic [COUNTW-1:0]         ts1Count,
  output logic [COUNTW-1:0]         ts2Count,
  output logic                      eightTs1,
  output logic                      eightTs2
);

  logic [MAXLANES-1:0]      lane_ts1, lane_ts2, lane_mask;
  logic [MAXLANES-1:0][7:0] sym1, sym2, sym3, sym4, sym5;
  logic [MAXLANES*8-1:0]    cur_lanes, lane_bits;
  logic                     all_ts1, all_ts2, fields_eq, all_lane_pad, same;
  os_type_e                 cur_type, hist_eff;

  os_type_e                 os_type_q, os_type_d, hist_type_q, hist_type_d;
  logic                     ts_valid_q, ts_valid_d, link_pad_q, link_pad_d, lane_pad_q, lane_pad_d;
  logic [7:0]               link_q, link_d, nfts_q, nfts_d, rate_q, rate_d, ctrl_q, ctrl_d;
  logic [MAXLANES*8-1:0]    lane_numbers_q, lane_numbers_d;
  logic [COUNTW-1:0]        ts1_count_q, ts1_count_d, ts2_count_q, ts2_count_d;

  for (genvar k = 0; k < MAXLANES; k++) begin : g_lane
    lane_ts_classifier u_cls (
      .slot   (orderedSets[lane_offset(k, 0) +: LANEW]),
      .is_ts1 (lane_ts1[k]),
      .is_ts2 (lane_ts2[k]),
      .sym1   (sym1[k]),
      .sym2   (sym2[k]),
      .sym3   (sym3[k]),
      .sym4   (sym4[k]),
      .sym5   (sym5[k])
    );
  end

  // Active-lane mask; unsupported widths fall back to a single lane
  always_comb begin
    case (numberOfDetectedLanes)
      5'd2:    lane_mask = 16'h0003;
      5'd4:    lane_mask = 16'h000F;
      5'd8:    lane_mask = 16'h00FF;
      5'd16:   lane_mask = 16'hFFFF;
      default: lane_mask = 16'h0001;
    endcase
  end

  // Cross-lane word classification and comparison against the previous word
  always_comb begin
    all_ts1      = 1'b1;
    all_ts2      = 1'b1;
    fields_eq    = 1'b1;
    all_lane_pad = 1'b1;
    cur_lanes    = '0;
    lane_bits    = '0;
    for (int k = 0; k < MAXLANES; k++) begin
      if (lane_mask[k]) begin
        all_ts1 &= lane_ts1[k];
        all_ts2 &= lane_ts2[k];
        if (sym1[k] != sym1[0] || sym3[k] != sym3[0] ||
            sym4[k] != sym4[0] || sym5[k] != sym5[0]) fields_eq = 1'b0;
        if (sym2[k] != PAD) all_lane_pad = 1'b0;
        cur_lanes[k*8 +: 8] = sym2[k];
        lane_bits[k*8 +: 8] = 8'hFF;
      end
    end
    if (all_ts1 && fields_eq)      cur_type = OS_TS1;
    else if (all_ts2 && fields_eq) cur_type = OS_TS2;
    else                           cur_type = OS_OTHER;
    // A coincident clear makes the incoming word count as the first of a run
    hist_eff = clearCounters ? OS_NONE : hist_type_q;
    same = (cur_type == hist_eff) && (sym1[0] == link_q) && (sym3[0] == nfts_q) &&
           (sym4[0] == rate_q) && (sym5[0] == ctrl_q) &&
           ((lane_numbers_q & lane_bits) == cur_lanes);
  end

  // Next-state for output fields, history and saturating run counters
  always_comb begin
    ts_valid_d     = osValid;
    os_type_d      = os_type_q;
    hist_type_d    = hist_type_q;
    link_d         = link_q;
    nfts_d         = nfts_q;
    rate_d         = rate_q;
    ctrl_d         = ctrl_q;
    lane_numbers_d = lane_numbers_q;
    link_pad_d     = link_pad_q;
    lane_pad_d     = lane_pad_q;
    ts1_count_d    = ts1_count_q;
    ts2_count_d    = ts2_count_q;
    if (osValid) begin
      os_type_d      = cur_type;
      hist_type_d    = cur_type;
      link_d         = sym1[0];
      nfts_d         = sym3[0];
      rate_d         = sym4[0];
      ctrl_d         = sym5[0];
      lane_numbers_d = cur_lanes;
      link_pad_d     = (sym1[0] == PAD);
      lane_pad_d     = all_lane_pad;
      ts1_count_d    = '0;
      ts2_count_d    = '0;
      if (cur_type == OS_TS1)
        ts1_count_d = !same ? COUNTW'(1) :
                      (&ts1_count_q) ? ts1_count_q : ts1_count_q + COUNTW'(1);
      if (cur_type == OS_TS2)
        ts2_count_d = !same ? COUNTW'(1) :
                      (&ts2_count_q) ? ts2_count_q : ts2_count_q + COUNTW'(1);
    end else if (clearCounters) begin
      hist_type_d = OS_NONE;
      ts1_count_d = '0;
      ts2_count_d = '0;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_valid_q     <= 1'b0;
      os_type_q      <= OS_NONE;
      hist_type_q    <= OS_NONE;
      link_q         <= '0;
      nfts_q         <= '0;
      rate_q         <= '0;
      ctrl_q         <= '0;
      lane_numbers_q <= '0;
      link_pad_q     <= 1'b0;
      lane_pad_q     <= 1'b0;
      ts1_count_q    <= '0;
      ts2_count_q    <= '0;
    end else begin
      ts_valid_q     <= ts_valid_d;
      os_type_q      <= os_type_d;
      hist_type_q    <= hist_type_d;
      link_q         <= link_d;
      nfts_q         <= nfts_d;
      rate_q         <= rate_d;
      ctrl_q         <= ctrl_d;
      lane_numbers_q <= lane_numbers_d;
      link_pad_q     <= link_pad_d;
      lane_pad_q     <= lane_pad_d;
      ts1_count_q    <= ts1_count_d;
      ts2_count_q    <= ts2_count_d;
    end
  end

  assign tsValid     = ts_valid_q;
  assign osType      = os_type_q;
  assign linkNumber  = link_q;
  assign laneNumbers = lane_numbers_q;
  assign nFts        = nfts_q;
  assign rateId      = rate_q;
  assign trainCtrl   = ctrl_q;
  assign linkPad     = link_pad_q;
  assign lanePad     = lane_pad_q;
  assign ts1Count    = ts1_count_q;
  assign ts2Count    = ts2_count_q;
  assign eightTs1    = (ts1_count_q >= COUNTW'(TARGET));
  assign eightTs2    = (ts2_count_q >= COUNTW'(TARGET));

endmodule

// File: tb/tb_os_analyzer.sv
// tb/tb_os_analyzer.sv - randomized self-checking bench for os_analyzer
module tb_os_analyzer;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          osValid = 1'b0;
  logic [2047:0] orderedSets = '0;
  logic [4:0]    numberOfDetectedLanes = 5'd1;
  logic          clearCounters = 1'b0;
  logic          tsValid, linkPad, lanePad, eightTs1, eightTs2;
  logic [1:0]    osType;
  logic [7:0]    linkNumber, nFts, rateId, trainCtrl;
  logic [127:0]  laneNumbers;
  logic [3:0]    ts1Count, ts2Count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] w [16][16];

  // Reference model state, kept as plain per-field values
  int         m_type, m_hist, m_c1, m_c2;
  bit         m_valid, m_lpad, m_lnpad;
  logic [7:0] m_link, m_nfts, m_rate, m_ctrl;
  logic [7:0] m_lanes [16];

  os_analyzer dut (
    .clk(clk), .reset(reset), .osValid(osValid), .orderedSets(orderedSets),
    .numberOfDetectedLanes(numberOfDetectedLanes), .clearCounters(clearCounters),
    .tsValid(tsValid), .osType(osType), .linkNumber(linkNumber), .laneNumbers(laneNumbers),
    .nFts(nFts), .rateId(rateId), .trainCtrl(trainCtrl), .linkPad(linkPad), .lanePad(lanePad),
    .ts1Count(ts1Count), .ts2Count(ts2Count), .eightTs1(eightTs1), .eightTs2(eightTs2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_type = 0; m_hist = 0; m_c1 = 0; m_c2 = 0;
    m_valid = 0; m_lpad = 0; m_lnpad = 0;
    m_link = 0; m_nfts = 0; m_rate = 0; m_ctrl = 0;
    for (int k = 0; k < 16; k++) m_lanes[k] = 0;
  endtask

  task automatic model_update(input int nl, input bit v, input bit clr);
    int act, t, hist;
    bit ok1, ok2, ident;
    act = (nl == 1 || nl == 2 || nl == 4 || nl == 8 || nl == 16) ? nl : 1;
    m_valid = v;
    if (!v) begin
      if (clr) begin m_hist = 0; m_c1 = 0; m_c2 = 0; end
      return;
    end
    ok1 = 1; ok2 = 1;
    for (int k = 0; k < act; k++) begin
      if (w[k][0] != 8'hBC) begin ok1 = 0; ok2 = 0; end
      for (int s = 6; s < 16; s++) begin
        if (w[k][s] != 8'h4A) ok1 = 0;
        if (w[k][s] != 8'h45) ok2 = 0;
      end
      if (w[k][1] != w[0][1] || w[k][3] != w[0][3] || w[k][4] != w[0][4] || w[k][5] != w[0][5]) begin
        ok1 = 0; ok2 = 0;
      end
    end
    t = ok1 ? 1 : (ok2 ? 2 : 3);
    hist = clr ? 0 : m_hist;
    ident = (t == hist) && (w[0][1] == m_link) && (w[0][3] == m_nfts) &&
            (w[0][4] == m_rate) && (w[0][5] == m_ctrl);
    for (int k = 0; k < act; k++) if (w[k][2] != m_lanes[k]) ident = 0;
    m_c1 = (t == 1) ? (ident ? ((m_c1 < 15) ? m_c1 + 1 : 15) : 1) : 0;
    m_c2 = (t == 2) ? (ident ? ((m_c2 < 15) ? m_c2 + 1 : 15) : 1) : 0;
    m_type = t; m_hist = t;
    m_link = w[0][1]; m_nfts = w[0][3]; m_rate = w[0][4]; m_ctrl = w[0][5];
    m_lpad = (w[0][1] == 8'hF7);
    m_lnpad = 1;
    for (int k = 0; k < 16; k++) begin
      m_lanes[k] = (k < act) ? w[k][2] : 8'h00;
      if (k < act && w[k][2] != 8'hF7) m_lnpad = 0;
    end
  endtask

  task automatic fill_ts(input int t, input logic [7:0] link, input logic [7:0] rate, input bit pad);
    for (int k = 0; k < 16; k++) begin
      w[k][0] = 8'hBC; w[k][1] = link; w[k][2] = pad ? 8'hF7 : 8'(k);
      w[k][3] = 8'h18; w[k][4] = rate; w[k][5] = 8'h00;
      for (int s = 6; s < 16; s++) w[k][s] = (t == 1) ? 8'h4A : 8'h45;
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input int nl, input bit v, input bit clr);
    logic [2047:0] bits;
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 16; s++) bits[k*128 + s*8 +: 8] = w[k][s];
    orderedSets = bits;
    numberOfDetectedLanes = 5'(nl);
    osValid = v;
    clearCounters = clr;
    model_update(nl, v, clr);
    @(posedge clk); #1;
    osValid = 1'b0;
    clearCounters = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({tsValid, osType, ts1Count, ts2Count, eightTs1, eightTs2, linkPad, lanePad} !== 14'h0) begin
      n_err++; $display("FAIL reset_ctrl: got %0h want 0", {tsValid, osType, ts1Count, ts2Count, eightTs1, eightTs2, linkPad, lanePad});
    end
    n_vec++;
    if ({linkNumber, nFts, rateId, trainCtrl, laneNumbers} !== 160'h0) begin
      n_err++; $display("FAIL reset_fields: got %0h want 0", {linkNumber, nFts, rateId, trainCtrl, laneNumbers});
    end
    reset = 1'b1;
  endtask

  task automatic test_eight_ts1();
    fill_ts(1, 8'h00, 8'h02, 0);
    for (int i = 0; i < 8; i++) begin
      step(4, 1, 0);
      n_vec++;
      if (ts1Count !== 4'(i + 1) || tsValid !== 1'b1 || osType !== 2'b01) begin
        n_err++; $display("FAIL eight_ts1_count: got cnt=%0d v=%0d t=%0d want cnt=%0d v=1 t=1", ts1Count, tsValid, osType, i + 1);
      end
      n_vec++;
      if (eightTs1 !== (i == 7) || linkPad !== 1'b0) begin
        n_err++; $display("FAIL eight_ts1_flag: got e=%0d lp=%0d want e=%0d lp=0", eightTs1, linkPad, (i == 7));
      end
    end
    n_vec++;
    if (laneNumbers !== 128'h03020100 || rateId !== 8'h02) begin
      n_err++; $display("FAIL eight_ts1_fields: got lanes=%0h rate=%0h want lanes=3020100 rate=2", laneNumbers, rateId);
    end
    step(4, 0, 0);
    n_vec++;
    if (tsValid !== 1'b0 || ts1Count !== 4'd8 || eightTs1 !== 1'b1) begin
      n_err++; $display("FAIL idle_hold: got v=%0d cnt=%0d e=%0d want v=0 cnt=8 e=1", tsValid, ts1Count, eightTs1);
    end
  endtask

  task automatic test_link_change();
    step(4, 0, 1);
    n_vec++;
    if (ts1Count !== 4'd0 || eightTs1 !== 1'b0 || osType !== 2'b01) begin
      n_err++; $display("FAIL clear_idle: got cnt=%0d e=%0d t=%0d want cnt=0 e=0 t=1", ts1Count, eightTs1, osType);
    end
    fill_ts(1, 8'h00, 8'h02, 0);
    for (int i = 0; i < 7; i++) step(4, 1, 0);
    fill_ts(1, 8'h01, 8'h02, 0);
    step(4, 1, 0);
    n_vec++;
    if (ts1Count !== 4'd1 || eightTs1 !== 1'b0 || linkNumber !== 8'h01) begin
      n_err++; $display("FAIL link_change: got cnt=%0d e=%0d link=%0h want cnt=1 e=0 link=1", ts1Count, eightTs1, linkNumber);
    end
  endtask

  task automatic test_ts2_after_ts1();
    fill_ts(1, 8'h00, 8'h02, 0);
    for (int i = 0; i < 8; i++) step(4, 1, 0);
    fill_ts(2, 8'h00, 8'h02, 0);
    for (int i = 0; i < 2; i++) begin
      step(4, 1, 0);
      n_vec++;
      if (osType !== 2'b10 || ts2Count !== 4'(i + 1) || ts1Count !== 4'd0 || eightTs1 !== 1'b0) begin
        n_err++; $display("FAIL ts2_after_ts1: got t=%0d c2=%0d c1=%0d e1=%0d want t=2 c2=%0d c1=0 e1=0", osType, ts2Count, ts1Count, eightTs1, i + 1);
      end
    end
  endtask

  task automatic test_other();
    fill_ts(1, 8'h00, 8'h02, 0);
    w[1][9] = 8'h00;
    step(2, 1, 0);
    n_vec++;
    if (osType !== 2'b11 || ts1Count !== 4'd0 || ts2Count !== 4'd0) begin
      n_err++; $display("FAIL other_word: got t=%0d c1=%0d c2=%0d want t=3 c1=0 c2=0", osType, ts1Count, ts2Count);
    end
    fill_ts(1, 8'h00, 8'h02, 0);
    for (int k = 8; k < 16; k++)
      for (int s = 0; s < 16; s++) w[k][s] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      step(4, 1, 0);
      n_vec++;
      if (osType !== 2'b01 || ts1Count !== 4'(i + 1)) begin
        n_err++; $display("FAIL inactive_garbage: got t=%0d c1=%0d want t=1 c1=%0d", osType, ts1Count, i + 1);
      end
    end
  endtask

  task automatic test_pad_clear();
    fill_ts(1, 8'hF7, 8'h02, 1);
    step(4, 1, 0);
    n_vec++;
    if (linkPad !== 1'b1 || lanePad !== 1'b1 || laneNumbers !== 128'hF7F7F7F7) begin
      n_err++; $display("FAIL pad_flags: got lp=%0d np=%0d lanes=%0h want 1 1 f7f7f7f7", linkPad, lanePad, laneNumbers);
    end
    for (int i = 0; i < 3; i++) step(4, 1, 0);
    n_vec++;
    if (ts1Count !== 4'd4) begin
      n_err++; $display("FAIL pad_run: got %0d want 4", ts1Count);
    end
    step(4, 1, 1);
    n_vec++;
    if (ts1Count !== 4'd1 || tsValid !== 1'b1) begin
      n_err++; $display("FAIL clear_with_valid: got cnt=%0d v=%0d want cnt=1 v=1", ts1Count, tsValid);
    end
  endtask

  task automatic test_reset_midstream();
    fill_ts(1, 8'h05, 8'h02, 0);
    for (int i = 0; i < 6; i++) step(8, 1, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({tsValid, osType, ts1Count, linkNumber, laneNumbers, eightTs1} !== 144'h0) begin
      n_err++; $display("FAIL reset_midstream: got %0h want 0", {tsValid, osType, ts1Count, linkNumber, laneNumbers, eightTs1});
    end
    #2 reset = 1'b1;
    step(8, 1, 0);
    n_vec++;
    if (ts1Count !== 4'd1 || linkNumber !== 8'h05) begin
      n_err++; $display("FAIL after_reset: got cnt=%0d link=%0h want cnt=1 link=5", ts1Count, linkNumber);
    end
  endtask

  task automatic test_random();
    int t, nl;
    logic [7:0] link;
    logic [127:0] exp_lanes;
    int nls [7] = '{1, 2, 4, 8, 16, 3, 0};
    t = 1; link = 8'h00; nl = 4;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) t = 3 - t;
      if ($urandom_range(0, 9) == 0) link = 8'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) nl = nls[$urandom_range(0, 6)];
      fill_ts(t, link, 8'h02, 0);
      if ($urandom_range(0, 7) == 0) w[$urandom_range(0, 15)][$urandom_range(0, 15)] = 8'($urandom);
      step(nl, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      for (int k = 0; k < 16; k++) exp_lanes[k*8 +: 8] = m_lanes[k];
      n_vec++;
      if (tsValid !== m_valid || osType !== 2'(m_type) || ts1Count !== 4'(m_c1) || ts2Count !== 4'(m_c2)) begin
        n_err++; $display("FAIL rand_ctrl it=%0d: got v=%0d t=%0d c1=%0d c2=%0d want v=%0d t=%0d c1=%0d c2=%0d",
                          it, tsValid, osType, ts1Count, ts2Count, m_valid, m_type, m_c1, m_c2);
      end
      n_vec++;
      if (eightTs1 !== (m_c1 >= 8) || eightTs2 !== (m_c2 >= 8) || linkPad !== m_lpad || lanePad !== m_lnpad) begin
        n_err++; $display("FAIL rand_flags it=%0d: got e1=%0d e2=%0d lp=%0d np=%0d want %0d %0d %0d %0d",
                          it, eightTs1, eightTs2, linkPad, lanePad, (m_c1 >= 8), (m_c2 >= 8), m_lpad, m_lnpad);
      end
      n_vec++;
      if (laneNumbers !== exp_lanes || {linkNumber, nFts, rateId, trainCtrl} !== {m_link, m_nfts, m_rate, m_ctrl}) begin
        n_err++; $display("FAIL rand_fields it=%0d: got %0h/%0h want %0h/%0h", it,
                          laneNumbers, {linkNumber, nFts, rateId, trainCtrl}, exp_lanes, {m_link, m_nfts, m_rate, m_ctrl});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 16; s++) w[k][s] = 8'h00;
    test_reset();
    test_eight_ts1();
    test_link_change();
    test_ts2_after_ts1();
    test_other();
    test_pad_clear();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/os_analyzer.md
# os_analyzer

Training-sequence analyzer downstream of the ordered-set decoder: consumes each lane-aligned 2048-bit ordered-set word and its valid strobe, classifies the word as TS1, TS2 or other across the active lanes, and extracts link number, per-lane lane numbers, N_FTS, data-rate and training-control symbols. It tracks consecutive identical TS1/TS2 counts and raises the "8 consecutive" qualifiers the LTSSM uses for Polling/Configuration transitions. All outputs are registered.

## Interface
- MAXLANES, 16, lane slots in the input word (128 bits each)
- COUNTW, 4, width of consecutive-OS counters
- TARGET, 8, count at which eightTs1/eightTs2 assert

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- osValid  in  1  one-cycle strobe: orderedSets holds a complete OS
- orderedSets  in  2048  lane k symbol s at bits [k*128 + s*8 +: 8]
- numberOfDetectedLanes  in  5  active lanes: 1/2/4/8/16; any other value treated as 1
- clearCounters  in  1  LTSSM state-entry pulse; zeroes counters and history
- tsValid  out  1  one-cycle pulse: outputs below updated this cycle
- osType  out  2  00 none, 01 TS1, 10 TS2, 11 other
- linkNumber  out  8  symbol 1 of lane 0
- laneNumbers  out  128  symbol 2 of lane k at [k*8 +: 8]; inactive lanes 0
- nFts  out  8  symbol 3 of lane 0
- rateId  out  8  symbol 4 of lane 0
- trainCtrl  out  8  symbol 5 of lane 0
- linkPad  out  1  linkNumber == PAD (F7)
- lanePad  out  1  every active lane's lane number == PAD
- ts1Count, ts2Count  out  COUNTW  consecutive identical TS1/TS2, saturating
- eightTs1, eightTs2  out  1  count >= TARGET

## Operation
- Lane classification (active lanes only): TS1 if symbol 0 == COM (BC) and symbols 6..15 all 4A; TS2 if COM and symbols 6..15 all 45; else other.
- Word type: TS1 if all active lanes TS1 and symbols 1, 3, 4, 5 equal across active lanes; TS2 likewise; else other (11). Inactive lanes ignored.
- History register: previous type, link, nFts, rate, trainCtrl, laneNumbers (active lanes). "Identical" = same type and all those fields equal.
- Counter update on osValid: TS1 identical to history -> ts1Count+1 saturating at 2^COUNTW-1; TS1 not identical -> ts1Count=1; ts2Count analogous; type other -> both 0; a TS1 sets ts2Count=0 and vice versa. History updated with every classified word (including other).
- eightTs1/eightTs2 combinational from registered counters; stay high while count >= TARGET.
- clearCounters without osValid: counters 0, history type = none; field outputs hold.
- clearCounters with osValid: clear wins, then incoming word counted fresh (TS -> its count 1, other 0).
- numberOfDetectedLanes change between words: next word compared against history masked by new lane count; lane-count change alone does not reset counters.

## Timing
- osValid at cycle N -> all outputs valid, tsValid high, from cycle N+1 (one-cycle latency).
- osValid on consecutive cycles supported; one update per strobe, no backpressure.
- tsValid low whenever osValid was low the previous cycle; other outputs hold.
- Reset (any time, including mid-stream): every output 0, osType 00, counters 0, history cleared; first word after release counts as 1 if TS.

## Structure
- Package pcie_os_pkg: COM (BC), PAD (F7), TS1_ID (4A), TS2_ID (45), osType codes, MAXLANES, lane-slot offset function.
- Sub-module lane_ts_classifier (combinational, one generated instance per lane): returns isTs1/isTs2 and symbols 1..5 for one 128-bit slot.
- Top: active-lane mask decode, cross-lane consistency, history compare, counters, output registers.

## Test plan
- 4 lanes, 8 identical TS1 (link 00, lanes 0..3, rate 02) on consecutive cycles -> ts1Count 1..8, eightTs1 high from cycle after 8th, linkPad 0.
- 7 identical TS1 then TS1 with link 01 -> ts1Count returns to 1, eightTs1 never asserts.
- 8 TS1 then 2 TS2 -> osType 10, ts2Count 1 then 2, ts1Count 0, eightTs1 drops.
- 2 lanes, lane 1 symbol 9 = 00 -> osType 11, both counts 0; lanes 8..15 garbage with 4 active lanes -> still TS1.
- TS1 with link/lanes = F7 -> linkPad 1, lanePad 1; clearCounters coincident with 5th TS1 -> ts1Count 1.
- Reset asserted after 6th TS1 -> all outputs 0 immediately; after release one TS1 -> ts1Count 1.
